// File: rtl/fetch_pkg.sv
// Shared types and constants for the fetch-stage PC generator.
package fetch_pkg;

  localparam int INSTR_BYTES = 4;
  localparam int FETCH_BYTES = 2 * INSTR_BYTES;

  // Prediction context captured when a request is issued to the I-cache.
  typedef struct packed {
    logic [31:0] pc;
    logic        taken;
    logic [31:0] target;
    logic        valid_b;
  } fetch_meta_t;

  // One fetch packet as held in the fetch queue.
  typedef struct packed {
    fetch_meta_t meta;
    logic [31:0] instr_a;
    logic [31:0] instr_b;
  } fetch_pkt_t;

endpackage

// File: rtl/sync_fifo.sv
// Generic single-clock FIFO with synchronous clear and occupancy count.
// Push to a full FIFO and pop from an empty FIFO are ignored. Clear wins
// over push and pop in the same cycle.
module sync_fifo #(
  parameter type T     = logic [7:0],
  parameter int  DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         push,
  input  T                             push_data,
  input  logic                         pop,
  input  logic                         clear,
  output T                             head,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  T              mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] cnt;
  logic          do_push;
  logic          do_pop;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    if (p == PW'(DEPTH - 1)) return '0;
    return p + PW'(1);
  endfunction

  assign full    = (cnt == CW'(DEPTH));
  assign empty   = (cnt == '0);
  assign count   = cnt;
  assign head    = mem[rd_ptr];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= next_ptr(wr_ptr);
      if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
      if (do_push && !do_pop)      cnt <= cnt + CW'(1);
      else if (!do_push && do_pop) cnt <= cnt - CW'(1);
    end
  end

  // Storage write; contents are only observed through head when non-empty.
  always_ff @(posedge clk) begin
    if (do_push && !clear) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/fetch_pc_unit.sv
// Fetch-stage PC generator and fetch queue.
// Holds the fetch PC, issues 8-byte I-cache requests, pairs in-order
// responses with the prediction metadata captured at issue, and buffers
// the resulting packets for decode.
//
// Handshakes: a transfer happens on a cycle where valid and ready are both
// high at the rising edge. valid never depends on ready. ic_req_valid may
// drop without a transfer (flush, credit exhaustion); fq_valid only drops
// after a pop or a flush.
module fetch_pc_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter int          FQ_DEPTH     = 4,
  parameter int          MAX_INFLIGHT = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        must_flush,
  input  logic [31:0] flush_pc,
  output logic [31:0] pred_pc,
  input  logic        pred_taken_a,
  input  logic [31:0] pred_next_pc_a,
  input  logic        pred_taken_b,
  input  logic [31:0] pred_next_pc_b,
  output logic        ic_req_valid,
  input  logic        ic_req_ready,
  output logic [31:0] ic_req_addr,
  input  logic        ic_resp_valid,
  input  logic [63:0] ic_resp_data,
  output logic        fq_valid,
  input  logic        fq_ready,
  output logic [31:0] fq_pc,
  output logic [31:0] fq_instr_a,
  output logic [31:0] fq_instr_b,
  output logic        fq_valid_b,
  output logic        fq_taken,
  output logic [31:0] fq_target
);

  localparam int IF_CW = $clog2(MAX_INFLIGHT + 1);
  localparam int FQ_CW = $clog2(FQ_DEPTH + 1);

  logic [31:0]      pc;
  logic [IF_CW-1:0] drop;
  logic [IF_CW-1:0] if_count;
  logic [IF_CW-1:0] live;
  logic [FQ_CW-1:0] fq_count;
  logic             if_full;
  logic             if_empty;
  logic             fq_full;
  logic             fq_empty;
  logic             credit_ok;
  logic             issue;
  logic             resp_pop;
  logic             fq_push;
  logic             fq_pop;
  logic [31:0]      next_pc;
  fetch_meta_t      issue_meta;
  fetch_meta_t      resp_meta;
  fetch_pkt_t       resp_pkt;
  fetch_pkt_t       fq_head;

  assign pred_pc     = pc;
  assign ic_req_addr = pc;

  // Responses still owed to the queue: those not already marked for discard.
  assign live      = if_count - drop;
  assign credit_ok = (32'(fq_count) + 32'(live)) < 32'(FQ_DEPTH);

  // Request only when both the inflight tracker and the queue have room.
  assign ic_req_valid = rst_n && !must_flush && !if_full && credit_ok;
  assign issue        = ic_req_valid && ic_req_ready;

  // Next-PC selection and metadata for the request leaving this cycle.
  always_comb begin
    next_pc    = pc + 32'(FETCH_BYTES);
    issue_meta = '0;
    issue_meta.pc = pc;
    if (pred_taken_a) begin
      next_pc            = pred_next_pc_a;
      issue_meta.taken   = 1'b1;
      issue_meta.target  = pred_next_pc_a;
      issue_meta.valid_b = 1'b0;
    end else if (pred_taken_b) begin
      next_pc            = pred_next_pc_b;
      issue_meta.taken   = 1'b1;
      issue_meta.target  = pred_next_pc_b;
      issue_meta.valid_b = 1'b1;
    end else begin
      issue_meta.taken   = 1'b0;
      issue_meta.target  = next_pc;
      issue_meta.valid_b = 1'b1;
    end
  end

  // A response always retires the oldest inflight entry; it reaches the
  // queue only if it belongs to the current (post-flush) fetch stream.
  assign resp_pop = ic_resp_valid && !if_empty;
  assign fq_push  = resp_pop && (drop == '0) && !must_flush;
  assign fq_pop   = fq_ready && !fq_empty;

  // Packet assembled from the response and its matching metadata.
  always_comb begin
    resp_pkt         = '0;
    resp_pkt.meta    = resp_meta;
    resp_pkt.instr_a = ic_resp_data[31:0];
    resp_pkt.instr_b = ic_resp_data[63:32];
  end

  // Fetch PC: redirect first, then advance on an accepted request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc <= RESET_PC;
    end else if (must_flush) begin
      pc <= flush_pc;
    end else if (issue) begin
      pc <= next_pc;
    end
  end

  // Discard counter: on flush every request still outstanding after this
  // cycle's response is stale. No request issues in a flush cycle, so the
  // inflight count can only shrink here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop <= '0;
    end else if (must_flush) begin
      drop <= if_count - (resp_pop ? IF_CW'(1) : IF_CW'(0));
    end else if (resp_pop && (drop != '0)) begin
      drop <= drop - IF_CW'(1);
    end
  end

  sync_fifo #(
    .T     (fetch_meta_t),
    .DEPTH (MAX_INFLIGHT)
  ) u_inflight (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (issue),
    .push_data (issue_meta),
    .pop       (resp_pop),
    .clear     (1'b0),
    .head      (resp_meta),
    .full      (if_full),
    .empty     (if_empty),
    .count     (if_count)
  );

  sync_fifo #(
    .T     (fetch_pkt_t),
    .DEPTH (FQ_DEPTH)
  ) u_fetch_q (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (fq_push),
    .push_data (resp_pkt),
    .pop       (fq_pop),
    .clear     (must_flush),
    .head      (fq_head),
    .full      (fq_full),
    .empty     (fq_empty),
    .count     (fq_count)
  );

  // Decode-facing view of the queue head, zeroed when nothing is queued.
  always_comb begin
    fq_valid   = !fq_empty;
    fq_pc      = '0;
    fq_instr_a = '0;
    fq_instr_b = '0;
    fq_valid_b = 1'b0;
    fq_taken   = 1'b0;
    fq_target  = '0;
    if (!fq_empty) begin
      fq_pc      = fq_head.meta.pc;
      fq_instr_a = fq_head.instr_a;
      fq_instr_b = fq_head.instr_b;
      fq_valid_b = fq_head.meta.valid_b;
      fq_taken   = fq_head.meta.taken;
      fq_target  = fq_head.meta.target;
    end
  end

  // Protocol checks on the I-cache and credit invariants.
  resp_needs_inflight: assert property (@(posedge clk) disable iff (!rst_n)
    ic_resp_valid |-> !if_empty);
  fq_never_overflows: assert property (@(posedge clk) disable iff (!rst_n)
    fq_push |-> !fq_full);

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Directed bench for fetch_pc_unit: a 1-cycle in-order I-cache model,
// hand-computed request and packet expectations, checked at negedges.
module tb_fetch_pc_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        must_flush;
  logic [31:0] flush_pc;
  logic [31:0] pred_pc;
  logic        pred_taken_a;
  logic [31:0] pred_next_pc_a;
  logic        pred_taken_b;
  logic [31:0] pred_next_pc_b;
  logic        ic_req_valid;
  logic        ic_req_ready;
  logic [31:0] ic_req_addr;
  logic        ic_resp_valid;
  logic [63:0] ic_resp_data;
  logic        fq_valid;
  logic        fq_ready;
  logic [31:0] fq_pc;
  logic [31:0] fq_instr_a;
  logic [31:0] fq_instr_b;
  logic        fq_valid_b;
  logic        fq_taken;
  logic [31:0] fq_target;

  int total = 0;
  int bad   = 0;

  // Expected packets: {pc[31:0], valid_b, taken, target[31:0]}.
  logic [65:0] exp_q[$];
  logic [31:0] req_exp_q[$];
  logic [31:0] pend_q[$];

  logic        hold;
  logic        ta_en, tb_en;
  logic [31:0] ta_pc, ta_tgt, tb_pc, tb_tgt;

  fetch_pc_unit dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .must_flush     (must_flush),
    .flush_pc       (flush_pc),
    .pred_pc        (pred_pc),
    .pred_taken_a   (pred_taken_a),
    .pred_next_pc_a (pred_next_pc_a),
    .pred_taken_b   (pred_taken_b),
    .pred_next_pc_b (pred_next_pc_b),
    .ic_req_valid   (ic_req_valid),
    .ic_req_ready   (ic_req_ready),
    .ic_req_addr    (ic_req_addr),
    .ic_resp_valid  (ic_resp_valid),
    .ic_resp_data   (ic_resp_data),
    .fq_valid       (fq_valid),
    .fq_ready       (fq_ready),
    .fq_pc          (fq_pc),
    .fq_instr_a     (fq_instr_a),
    .fq_instr_b     (fq_instr_b),
    .fq_valid_b     (fq_valid_b),
    .fq_taken       (fq_taken),
    .fq_target      (fq_target)
  );

  // Clock and watchdog.
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] instr_a_of(input logic [31:0] pc);
    return pc ^ 32'hA5A5_A5A5;
  endfunction

  function automatic logic [31:0] instr_b_of(input logic [31:0] pc);
    return pc + 32'h1234_0004;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input logic [31:0] pc, input logic vb, input logic tk,
                          input logic [31:0] tgt);
    exp_q.push_back({pc, vb, tk, tgt});
  endtask

  // One clock cycle, entered and left just after a negedge.
  task automatic cycle();
    logic [65:0] e;
    logic        resp_given;
    pred_taken_a   = ta_en && (pred_pc == ta_pc);
    pred_next_pc_a = pred_taken_a ? ta_tgt : 32'hDEAD_0000;
    pred_taken_b   = tb_en && (pred_pc == tb_pc);
    pred_next_pc_b = pred_taken_b ? tb_tgt : 32'hBEEF_0000;
    #2;
    if (ic_req_valid && ic_req_ready) begin
      if (req_exp_q.size() == 0) begin
        total++;
        bad++;
        $error("FAIL req_unexpected observed=%h expected=none", ic_req_addr);
      end else begin
        chk("req_addr", ic_req_addr, req_exp_q.pop_front());
      end
      pend_q.push_back(ic_req_addr);
    end
    if (fq_valid && fq_ready) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $error("FAIL pkt_unexpected observed=%h expected=none", fq_pc);
      end else begin
        e = exp_q.pop_front();
        chk("pkt_pc", fq_pc, e[65:34]);
        chk("pkt_valid_b", 32'(fq_valid_b), 32'(e[33]));
        chk("pkt_taken", 32'(fq_taken), 32'(e[32]));
        if (e[32]) chk("pkt_target", fq_target, e[31:0]);
        chk("pkt_instr_a", fq_instr_a, instr_a_of(e[65:34]));
        chk("pkt_instr_b", fq_instr_b, instr_b_of(e[65:34]));
      end
    end
    resp_given = ic_resp_valid;
    @(posedge clk);
    @(negedge clk);
    if (resp_given) void'(pend_q.pop_front());
    if (!hold && pend_q.size() > 0) begin
      ic_resp_valid = 1'b1;
      ic_resp_data  = {instr_b_of(pend_q[0]), instr_a_of(pend_q[0])};
    end else begin
      ic_resp_valid = 1'b0;
      ic_resp_data  = '0;
    end
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 50; i++) begin
      if (exp_q.size() == 0 && pend_q.size() == 0) break;
      cycle();
    end
    chk({tag, "_pkts_left"}, 32'(exp_q.size() + pend_q.size()), 32'd0);
    chk({tag, "_reqs_left"}, 32'(req_exp_q.size()), 32'd0);
  endtask

  task automatic do_flush(input logic [31:0] target);
    must_flush = 1'b1;
    flush_pc   = target;
    #1;
    chk("flush_no_req", 32'(ic_req_valid), 32'd0);
    cycle();
    must_flush = 1'b0;
    chk("flush_pc_loaded", pred_pc, target);
    chk("flush_fq_empty", 32'(fq_valid), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; must_flush = 1'b0; flush_pc = '0;
    pred_taken_a = 1'b0; pred_next_pc_a = '0; pred_taken_b = 1'b0; pred_next_pc_b = '0;
    ic_req_ready = 1'b0; ic_resp_valid = 1'b0; ic_resp_data = '0; fq_ready = 1'b1;
    hold = 1'b0; ta_en = 1'b0; tb_en = 1'b0;
    ta_pc = '0; ta_tgt = '0; tb_pc = '0; tb_tgt = '0;

    // Reset state.
    #1;
    chk("rst_pred_pc", pred_pc, 32'h0);
    chk("rst_req_valid", 32'(ic_req_valid), 32'd0);
    chk("rst_fq_valid", 32'(fq_valid), 32'd0);
    chk("rst_fq_pc", fq_pc, 32'h0);
    chk("rst_fq_instr_a", fq_instr_a, 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Sequential fetch with a slot-a taken branch at 0x8 -> 0x100.
    foreach (req_exp_q[i]) ;
    req_exp_q = '{32'h0, 32'h8, 32'h100, 32'h108, 32'h110};
    push_exp(32'h0,   1'b1, 1'b0, 32'h0);
    push_exp(32'h8,   1'b0, 1'b1, 32'h100);
    push_exp(32'h100, 1'b1, 1'b0, 32'h0);
    push_exp(32'h108, 1'b1, 1'b0, 32'h0);
    push_exp(32'h110, 1'b1, 1'b0, 32'h0);
    ta_en = 1'b1; ta_pc = 32'h8; ta_tgt = 32'h100;
    ic_req_ready = 1'b1;
    cycle();
    chk("seq_pc_plus8", pred_pc, 32'h8);
    chk("lat_n1_fq_valid", 32'(fq_valid), 32'd0);
    cycle();
    chk("taken_a_pc", pred_pc, 32'h100);
    chk("lat_n2_fq_valid", 32'(fq_valid), 32'd1);
    chk("lat_n2_fq_pc", fq_pc, 32'h0);
    repeat (3) cycle();
    ic_req_ready = 1'b0;
    ta_en = 1'b0;
    drain("seq");

    // Backpressure: decode stalled, queue fills to exactly four packets.
    do_flush(32'h400);
    fq_ready = 1'b0;
    ic_req_ready = 1'b1;
    req_exp_q = '{32'h400, 32'h408, 32'h410, 32'h418};
    repeat (10) cycle();
    chk("bp_fq_valid", 32'(fq_valid), 32'd1);
    chk("bp_req_blocked", 32'(ic_req_valid), 32'd0);
    chk("bp_head_pc", fq_pc, 32'h400);
    chk("bp_pc_held", pred_pc, 32'h420);
    chk("bp_req_count", 32'(req_exp_q.size()), 32'd0);
    ic_req_ready = 1'b0;
    push_exp(32'h400, 1'b1, 1'b0, 32'h0);
    push_exp(32'h408, 1'b1, 1'b0, 32'h0);
    push_exp(32'h410, 1'b1, 1'b0, 32'h0);
    push_exp(32'h418, 1'b1, 1'b0, 32'h0);
    fq_ready = 1'b1;
    drain("bp");

    // Flush with two requests outstanding: both responses are dropped.
    hold = 1'b1;
    ic_req_ready = 1'b1;
    req_exp_q = '{32'h420, 32'h428};
    repeat (2) cycle();
    chk("inflight_full", 32'(ic_req_valid), 32'd0);
    do_flush(32'h200);
    hold = 1'b0;
    ic_req_ready = 1'b0;
    repeat (3) begin
      cycle();
      chk("drop_fq_empty", 32'(fq_valid), 32'd0);
    end
    chk("drop_pc_kept", pred_pc, 32'h200);
    req_exp_q = '{32'h200};
    push_exp(32'h200, 1'b1, 1'b0, 32'h0);
    ic_req_ready = 1'b1;
    cycle();
    ic_req_ready = 1'b0;
    drain("drop");

    // Slot-b taken branch at 0x10 -> 0x40.
    do_flush(32'h10);
    tb_en = 1'b1; tb_pc = 32'h10; tb_tgt = 32'h40;
    req_exp_q = '{32'h10, 32'h40, 32'h48};
    push_exp(32'h10, 1'b1, 1'b1, 32'h40);
    push_exp(32'h40, 1'b1, 1'b0, 32'h0);
    push_exp(32'h48, 1'b1, 1'b0, 32'h0);
    ic_req_ready = 1'b1;
    cycle();
    chk("taken_b_pc", pred_pc, 32'h40);
    repeat (2) cycle();
    ic_req_ready = 1'b0;
    tb_en = 1'b0;
    drain("taken_b");

    // PC wrap, then a flush in the same cycle as a response.
    do_flush(32'hFFFF_FFF8);
    req_exp_q = '{32'hFFFF_FFF8, 32'h0};
    push_exp(32'hFFFF_FFF8, 1'b1, 1'b0, 32'h0);
    ic_req_ready = 1'b1;
    cycle();
    chk("wrap_pc", pred_pc, 32'h0);
    cycle();
    chk("wrap_pc_next", pred_pc, 32'h8);
    ic_req_ready = 1'b0;
    chk("wrap_resp_pending", 32'(ic_resp_valid), 32'd1);
    do_flush(32'h600);
    req_exp_q = '{32'h600};
    push_exp(32'h600, 1'b1, 1'b0, 32'h0);
    ic_req_ready = 1'b1;
    cycle();
    ic_req_ready = 1'b0;
    drain("wrap");

    // Reset in the middle of an outstanding request.
    req_exp_q = '{32'h608};
    ic_req_ready = 1'b1;
    cycle();
    ic_req_ready = 1'b0;
    rst_n = 1'b0;
    ic_resp_valid = 1'b0;
    ic_resp_data = '0;
    pend_q.delete();
    #1;
    chk("midrst_pred_pc", pred_pc, 32'h0);
    chk("midrst_req_valid", 32'(ic_req_valid), 32'd0);
    chk("midrst_fq_valid", 32'(fq_valid), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("post_rst_req_valid", 32'(ic_req_valid), 32'd1);
    chk("post_rst_pred_pc", pred_pc, 32'h0);
    chk("final_reqs_left", 32'(req_exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
